mul_div_issue_ctrl: RTL and testbench

- Issue/sequencing stage directly upstream of the 32x32 unsigned multiplier in the execute path.
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from decode/issue.
- Converts signed operands to magnitudes, drives the multiplier, and waits for its completion flag.
- Applies sign correction, selects the low or high word, and returns the result to writeback over a valid/ready handshake.

---
 rtl/mul_div_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_mul_div_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_issue_ctrl.sv
// Issue/sequencing stage in front of the 32x32 unsigned multiplier: RV32M sign handling, launch/wait/fix, valid/ready result.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the multiplier and produces 0 directly. WAIT_MAX must be >= 8.
module mul_div_issue_ctrl #(
  parameter int TAG_W    = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_rs1,
  input  logic [31:0]       req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic [31:0]       mul_op1,
  output logic [31:0]       mul_op2,
  input  logic [63:0]       mul_answer,
  input  logic              mul_done,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FIX    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_mul_op1;
  logic [31:0]      r_mul_op2;
  logic [63:0]      r_prod;
  logic             r_neg;
  logic             r_hi;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_err;

  logic             w_s1;
  logic             w_s2;
  logic [31:0]      w_mag1;
  logic [31:0]      w_mag2;
  logic             w_accept;
  logic             w_bypass;
  logic             w_wait_expired;
  logic             w_timeout;
  logic [63:0]      w_prod_signed;

  // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
  assign w_s1   = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) && req_rs1[31];
  assign w_s2   = (req_op == OP_MULH) && req_rs2[31];
  assign w_mag1 = w_s1 ? (~req_rs1 + 32'd1) : req_rs1;
  assign w_mag2 = w_s2 ? (~req_rs2 + 32'd1) : req_rs2;

`ifdef MUL_ZERO_BYPASS_EN
  assign w_bypass = (req_rs1 == 32'd0) || (req_rs2 == 32'd0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept       = (r_state == S_IDLE) && req_valid && !flush;
  assign w_wait_expired = (r_wait_cnt == CNT_LAST);
  assign w_timeout      = (r_state == S_WAIT) && !mul_done && w_wait_expired && !flush;
  assign w_prod_signed  = r_neg ? (~mul_answer + 64'd1) : mul_answer;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_bypass ? S_FIX : S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_done)            w_state_nxt = S_FIX;
        else if (w_wait_expired) w_state_nxt = S_IDLE;
      end
      S_FIX:    w_state_nxt = S_DONE;
      S_DONE:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // flush wins over everything, including acceptance in IDLE and a handshake in DONE.
    if (flush) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      r_err      <= w_timeout;
    end
  end

  // NOTE: datapath registers are reset too, because their reset values are visible on the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_op1   <= '0;
      r_mul_op2   <= '0;
      r_prod      <= '0;
      r_neg       <= 1'b0;
      r_hi        <= 1'b0;
      r_tag       <= '0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
    end else begin
      if (w_accept) begin
        r_neg <= w_s1 ^ w_s2;
        r_hi  <= (req_op != OP_MUL);
        r_tag <= req_tag;
        if (w_bypass) begin
          r_prod <= '0;
        end else begin
          r_mul_op1 <= w_mag1;
          r_mul_op2 <= w_mag2;
        end
      end
      if ((r_state == S_WAIT) && mul_done) r_prod <= w_prod_signed;
      if (r_state == S_FIX) begin
        r_resp_data <= r_hi ? r_prod[63:32] : r_prod[31:0];
        r_resp_tag  <= r_tag;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign mul_op1    = r_mul_op1;
  assign mul_op2    = r_mul_op2;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;
  assign err        = r_err;

endmodule

// File: tb/tb_mul_div_issue_ctrl.sv
// Scoreboard bench for mul_div_issue_ctrl with a behavioural multiplier that completes
// five edges after its operands settle; directed vectors with hand-computed results.
module tb_mul_div_issue_ctrl;
  localparam int TAG_W    = 5;
  localparam int WAIT_MAX = 15;
  // Accept cycle, LAUNCH, 6 WAIT cycles for a fresh operand pair, FIX, then DONE.
  localparam int LAT_FRESH = 9;
  localparam int LAT_ERR   = 2 + WAIT_MAX;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_rs1;
  logic [31:0]       req_rs2;
  logic [TAG_W-1:0]  req_tag;
  logic              flush;
  logic [31:0]       mul_op1;
  logic [31:0]       mul_op2;
  logic [63:0]       mul_answer;
  logic              mul_done;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              err;

  mul_div_issue_ctrl #(.TAG_W(TAG_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_answer(mul_answer), .mul_done(mul_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Multiplier model: product registered once operands have been stable for five edges.
  logic [31:0] m_p1, m_p2;
  logic [2:0]  m_cnt;
  logic [63:0] m_ans;
  logic        hang;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 <= '0; m_p2 <= '0; m_cnt <= '0; m_ans <= '0;
    end else begin
      if ({mul_op1, mul_op2} != {m_p1, m_p2}) m_cnt <= '0;
      else if (m_cnt < 3'd5) begin
        m_cnt <= m_cnt + 3'd1;
        if (m_cnt == 3'd4) m_ans <= 64'(m_p1) * 64'(m_p2);
      end
      m_p1 <= mul_op1;
      m_p2 <= mul_op2;
    end
  end
  assign mul_done   = !hang && (m_cnt == 3'd5);
  assign mul_answer = m_ans;

  // Scoreboard and monitor.
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;
  int   rise_lat   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && !prev_valid) rise_lat = cyc - accept_cyc;
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("resp_without_request", 64'(resp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_data", 64'(resp_data), 64'(mon_e.data));
          check("resp_tag", 64'(resp_tag), 64'(mon_e.tag));
          check("resp_latency", 64'(rise_lat), 64'(mon_e.lat));
        end
      end
    end
    prev_valid = resp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [TAG_W-1:0] tag, input logic [31:0] e_op1,
                       input logic [31:0] e_op2, input logic [31:0] e_data,
                       input int e_lat, input bit push);
    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_tag = tag; req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_at_issue", 64'(req_ready), 64'd1);
    accept_cyc = cyc;
    if (push) sb.push_back('{data: e_data, tag: tag, lat: e_lat});
    tick();
    req_valid = 1'b0;
    check("mul_op1", 64'(mul_op1), 64'(e_op1));
    check("mul_op2", 64'(mul_op2), 64'(e_op2));
  endtask

  task automatic wait_idle(input string name);
    @(negedge clk);
    for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
    check(name, 64'(req_ready), 64'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_mul_op1"}, 64'(mul_op1), 64'd0);
    check({tag, "_mul_op2"}, 64'(mul_op2), 64'd0);
    check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    check({tag, "_resp_tag"}, 64'(resp_tag), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
    req_tag = '0; flush = 1'b0; resp_ready = 1'b1; hang = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) tick();

    // MULHU all-ones; stale mul_done from reset is high during LAUNCH.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, LAT_FRESH, 1);
    wait_idle("idle_after_mulhu");

    // MULH -2 * 3 = -6, high word.
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 5'd2, 32'd2, 32'd3, 32'hFFFF_FFFF, LAT_FRESH, 1);
    wait_idle("idle_after_mulh");

    // MUL same operands: unsigned magnitudes differ, stale done/answer(6) present in LAUNCH.
    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 5'd3, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, LAT_FRESH, 1);
    wait_idle("idle_after_mul");

    // MULHSU most-negative * 0xFFFFFFFF = 0x8000000080000000.
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, LAT_FRESH, 1);
    wait_idle("idle_after_mulhsu");

    // Backpressure: 0xFFFF * 0x10001 = 0xFFFFFFFF low word.
    resp_ready = 1'b0;
    issue(2'b00, 32'h0000_FFFF, 32'h0001_0001, 5'h15, 32'h0000_FFFF, 32'h0001_0001,
          32'hFFFF_FFFF, LAT_FRESH, 1);
    @(negedge clk);
    for (int i = 0; i < 60 && !resp_valid; i++) @(negedge clk);
    check("bp_resp_valid_seen", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_resp_valid_held", 64'(resp_valid), 64'd1);
      check("bp_resp_data_held", 64'(resp_data), 64'hFFFF_FFFF);
      check("bp_resp_tag_held", 64'(resp_tag), 64'h15);
      check("bp_req_ready_low", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_req_ready_after", 64'(req_ready), 64'd1);
    check("bp_resp_valid_after", 64'(resp_valid), 64'd0);

    // Flush while in WAIT: no response, no err, back to IDLE.
    issue(2'b11, 32'd7, 32'd9, 5'd6, 32'd7, 32'd9, 32'd0, LAT_FRESH, 0);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wait_idle", 64'(req_ready), 64'd1);
    check("flush_wait_no_valid", 64'(resp_valid), 64'd0);
    check("flush_wait_no_err", 64'(err), 64'd0);
    repeat (12) tick();

    // Flush in IDLE beats a request.
    req_op = 2'b00; req_rs1 = 32'hAA; req_rs2 = 32'hBB; req_tag = 5'd9;
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", 64'(req_ready), 64'd1);
    check("flush_idle_op1_kept", 64'(mul_op1), 64'd7);
    repeat (12) tick();

    // Multiplier never completes: err pulse after WAIT_MAX cycles in WAIT.
    hang = 1'b1;
    issue(2'b00, 32'h11, 32'h22, 5'd7, 32'h11, 32'h22, 32'd0, LAT_FRESH, 0);
    @(negedge clk);
    for (int i = 0; i < 40 && !err; i++) @(negedge clk);
    check("err_seen", 64'(err), 64'd1);
    check("err_latency", 64'(cyc - accept_cyc), 64'(LAT_ERR));
    check("err_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'd0);
    hang = 1'b0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    issue(2'b11, 32'h1234, 32'h5678, 5'd8, 32'h1234, 32'h5678, 32'd0, LAT_FRESH, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) tick();

    // Zero operand.
`ifdef MUL_ZERO_BYPASS_EN
    issue(2'b00, 32'd5, 32'd0, 5'd10, 32'd0, 32'd0, 32'd0, 2, 1);
`else
    issue(2'b00, 32'd5, 32'd0, 5'd10, 32'd5, 32'd0, 32'd0, LAT_FRESH, 1);
`endif
    wait_idle("idle_after_zero");

    repeat (4) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
